// File: rtl/lcd_pixel_stream.sv
// lcd_pixel_stream: pixel byte FIFO feeding the LCD data bus.
// Bytes from the framebuffer side are queued in a first-word fall-through FIFO
// and popped one per falling CLKIN edge while H_DONE & V_DONE mark the visible
// window. Streaming starts at the first V_SYNC falling edge after reset.
module lcd_pixel_stream #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned AW           = 10,
    parameter logic [7:0]  BLANK_COLOR  = 8'h00,
    parameter int unsigned PIX_PER_LINE = 960
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          CLKIN,
    input  logic          H_DONE,
    input  logic          V_DONE,
    input  logic          V_SYNC,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          wr_full,
    output logic [AW:0]   wr_level,
    input  logic          clr_err,
    output logic [7:0]    dataLCD,
    output logic          frame_start,
    output logic [10:0]   px_cnt,
    output logic          underrun,
    output logic          overflow
);

    localparam logic [0:0]  ST_WAIT_FRAME = 1'b0;
    localparam logic [0:0]  ST_STREAM     = 1'b1;
    localparam logic [AW:0] LVL_FULL      = (AW+1)'(DEPTH);
    localparam logic [10:0] PX_MAX        = 11'(PIX_PER_LINE - 1);

    logic [0:0]  r_state;
    logic        r_clkin_q;
    logic        r_vsync_q;
    logic        r_frame_start;
    logic [7:0]  r_data;
    logic [10:0] r_px_cnt;
    logic        r_underrun;
    logic        r_overflow;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [DEPTH];

    logic        w_tick;
    logic        w_fs;
    logic        w_vis_tick;
    logic [AW:0] w_level;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_wr_accept;
    logic        w_underrun_ev;
    logic        w_overflow_ev;
    logic [7:0]  w_head;

    assign w_tick     = r_clkin_q & ~CLKIN;
    assign w_fs       = r_vsync_q & ~V_SYNC;
    assign w_vis_tick = (r_state == ST_STREAM) & w_tick & H_DONE & V_DONE;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == LVL_FULL);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_pop         = w_vis_tick & ~w_empty;
    // A pop in the same cycle frees a slot, so a write at full still lands.
    assign w_wr_accept   = wr_en & (~w_full | w_pop);
    assign w_underrun_ev = w_vis_tick & w_empty;
    assign w_overflow_ev = wr_en & ~w_wr_accept;

    assign wr_full     = w_full;
    assign wr_level    = w_level;
    assign dataLCD     = r_data;
    assign frame_start = r_frame_start;
    assign px_cnt      = r_px_cnt;
    assign underrun    = r_underrun;
    assign overflow    = r_overflow;

    // Edge-detect registers for the pixel clock level and vertical sync.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_clkin_q     <= 1'b0;
            r_vsync_q     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_clkin_q     <= CLKIN;
            r_vsync_q     <= V_SYNC;
            r_frame_start <= w_fs;
        end
    end

    // Frame state: wait for the first frame start, then stream until reset.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_WAIT_FRAME;
        end else if (r_state == ST_WAIT_FRAME && w_fs) begin
            r_state <= ST_STREAM;
        end
    end

    // LCD data bus and pixel index, updated only on pixel ticks while streaming.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_data   <= 8'h00;
            r_px_cnt <= '0;
        end else if (r_state == ST_WAIT_FRAME) begin
            r_data   <= 8'h00;
            r_px_cnt <= '0;
        end else if (w_tick) begin
            if (H_DONE && V_DONE) begin
                r_data <= w_empty ? BLANK_COLOR : w_head;
                if (r_px_cnt != PX_MAX) begin
                    r_px_cnt <= r_px_cnt + 11'd1;
                end
            end else begin
                r_data   <= 8'h00;
                r_px_cnt <= '0;
            end
        end
    end

    // FIFO pointers; a reset discards anything queued.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // FIFO storage, left unreset so it can map onto RAM.
    always_ff @(posedge sys_clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Sticky error flags; a coincident new event beats the clear.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clr_err) begin
            r_underrun <= w_underrun_ev;
            r_overflow <= w_overflow_ev;
        end else begin
            r_underrun <= r_underrun | w_underrun_ev;
            r_overflow <= r_overflow | w_overflow_ev;
        end
    end

endmodule

// File: tb/tb_lcd_pixel_stream.sv
// Bench for lcd_pixel_stream: a fixed vector table from reset, hand-written
// corner sequences, and a randomized run against a queue-based reference model.
module tb_lcd_pixel_stream;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam logic [7:0]  BLANK = 8'hA5;
    localparam int unsigned PPL   = 20;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b0;
    logic          CLKIN = 1'b0;
    logic          H_DONE = 1'b0;
    logic          V_DONE = 1'b0;
    logic          V_SYNC = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_full;
    logic [AW:0]   wr_level;
    logic          clr_err = 1'b0;
    logic [7:0]    dataLCD;
    logic          frame_start;
    logic [10:0]   px_cnt;
    logic          underrun;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_chk = 1'b0;

    // Reference model state.
    byte unsigned q[$];
    bit           m_stream;
    logic [7:0]   m_data;
    int           m_px;
    bit           m_und, m_ovf, m_fs;
    bit           m_prev_ck, m_prev_vs;

    lcd_pixel_stream #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .BLANK_COLOR (BLANK),
        .PIX_PER_LINE(PPL)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .CLKIN      (CLKIN),
        .H_DONE     (H_DONE),
        .V_DONE     (V_DONE),
        .V_SYNC     (V_SYNC),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .wr_level   (wr_level),
        .clr_err    (clr_err),
        .dataLCD    (dataLCD),
        .frame_start(frame_start),
        .px_cnt     (px_cnt),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_stream  = 1'b0;
        m_data    = 8'h00;
        m_px      = 0;
        m_und     = 1'b0;
        m_ovf     = 1'b0;
        m_fs      = 1'b0;
        m_prev_ck = 1'b0;
        m_prev_vs = 1'b1;
    endtask

    // One sys_clk cycle of the specified behaviour: pop (or blank) first,
    // then the write, which lands if there is room after the pop.
    task automatic model_step(input bit ck, input bit h, input bit v, input bit vs,
                              input bit we, input logic [7:0] wd, input bit clr);
        bit tick, fs, uev, oev;
        tick = m_prev_ck && !ck;
        fs   = m_prev_vs && !vs;
        uev  = 1'b0;
        oev  = 1'b0;
        if (m_stream && tick) begin
            if (h && v) begin
                if (q.size() > 0) begin
                    m_data = q.pop_front();
                end else begin
                    m_data = BLANK;
                    uev    = 1'b1;
                end
                if (m_px < int'(PPL) - 1) m_px++;
            end else begin
                m_data = 8'h00;
                m_px   = 0;
            end
        end
        if (we) begin
            if (q.size() < DEPTH) q.push_back(wd);
            else oev = 1'b1;
        end
        m_und = clr ? uev : (m_und | uev);
        m_ovf = clr ? oev : (m_ovf | oev);
        m_fs  = fs;
        if (fs) m_stream = 1'b1;
        m_prev_ck = ck;
        m_prev_vs = vs;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".data"},  32'(dataLCD),     32'(m_data));
        chk({tag, ".level"}, 32'(wr_level),    32'(q.size()));
        chk({tag, ".full"},  32'(wr_full),     32'(q.size() == DEPTH));
        chk({tag, ".fs"},    32'(frame_start), 32'(m_fs));
        chk({tag, ".px"},    32'(px_cnt),      32'(m_px));
        chk({tag, ".und"},   32'(underrun),    32'(m_und));
        chk({tag, ".ovf"},   32'(overflow),    32'(m_ovf));
    endtask

    // Drive one cycle of inputs, clock it, advance the model, sample at +1.
    task automatic cyc(input bit ck, input bit h, input bit v, input bit vs,
                       input bit we, input logic [7:0] wd, input bit clr);
        CLKIN   = ck;
        H_DONE  = h;
        V_DONE  = v;
        V_SYNC  = vs;
        wr_en   = we;
        wr_data = wd;
        clr_err = clr;
        @(posedge sys_clk);
        model_step(ck, h, v, vs, we, wd, clr);
        #1;
        if (model_chk) check_model("model");
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        CLKIN  = 1'b0;
        V_SYNC = 1'b1;
        wr_en  = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    // Tick pair: CLKIN high then low; the tick (and optional write) is the 2nd cycle.
    task automatic tk(input bit h, input bit vs, input bit we, input logic [7:0] wd);
        cyc(1'b1, h, 1'b1, vs, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, h, 1'b1, vs, we, wd, 1'b0);
    endtask

    typedef struct {
        logic       ck, h, v, vs, we;
        logic [7:0] wd;
        logic       clr;
        logic [7:0] e_data;
        logic [4:0] e_lvl;
        logic       e_fs, e_und;
        logic [10:0] e_px;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // ck h  v  vs we wd     clr   data   lvl fs und px
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 11'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0, 11'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0, 11'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'd2, 1'b1, 1'b0, 11'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 11'd1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 11'd1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 5'd0, 1'b0, 1'b0, 11'd2};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 5'd0, 1'b0, 1'b0, 11'd2};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, BLANK, 5'd0, 1'b0, 1'b1, 11'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, BLANK, 5'd0, 1'b0, 1'b0, 11'd3};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 11'd0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 11'd0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 8'h33, 5'd1, 1'b0, 1'b0, 11'd1};

        // ---------------- Vector table from reset ----------------
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].ck, tbl[i].h, tbl[i].v, tbl[i].vs, tbl[i].we, tbl[i].wd, tbl[i].clr);
            chk($sformatf("tbl%0d.data", i),  32'(dataLCD),     32'(tbl[i].e_data));
            chk($sformatf("tbl%0d.level", i), 32'(wr_level),    32'(tbl[i].e_lvl));
            chk($sformatf("tbl%0d.fs", i),    32'(frame_start), 32'(tbl[i].e_fs));
            chk($sformatf("tbl%0d.und", i),   32'(underrun),    32'(tbl[i].e_und));
            chk($sformatf("tbl%0d.px", i),    32'(px_cnt),      32'(tbl[i].e_px));
        end

        // ---------------- Reset then idle ----------------
        model_chk = 1'b1;
        do_reset();
        #1;
        chk("rst.data", 32'(dataLCD), 32'h0);
        chk("rst.level", 32'(wr_level), 32'h0);
        chk("rst.flags", 32'({underrun, overflow, frame_start, wr_full}), 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAB, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hCD, 1'b0);
        for (int i = 0; i < 4; i++) tk(1'b1, 1'b1, 1'b0, 8'h00);
        chk("idle.no_pop.level", 32'(wr_level), 32'd2);
        chk("idle.no_pop.data", 32'(dataLCD), 32'h0);

        // ---------------- Prefill and stream ----------------
        do_reset();
        for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'(i), 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("stream.frame_start", 32'(frame_start), 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("stream.frame_start_drop", 32'(frame_start), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("stream.data%0d", i), 32'(dataLCD), 32'(i));
            chk($sformatf("stream.px%0d", i), 32'(px_cnt), 32'(i));
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        chk("stream.level_empty", 32'(wr_level), 32'd0);

        // ---------------- Full / overflow / simultaneous ----------------
        do_reset();
        for (int i = 0; i <= int'(DEPTH); i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
        chk("ovf.full", 32'(wr_full), 32'd1);
        chk("ovf.level", 32'(wr_level), 32'(DEPTH));
        chk("ovf.flag", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("ovf.clr", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tk(1'b1, 1'b0, 1'b1, 8'h77);
        chk("simul_full.level", 32'(wr_level), 32'(DEPTH));
        chk("simul_full.ovf", 32'(overflow), 32'd0);
        chk("simul_full.data", 32'(dataLCD), 32'h40);
        for (int i = 0; i < 40 && wr_level != 5; i++) tk(1'b1, 1'b0, 1'b0, 8'h00);
        chk("simul5.reached", 32'(wr_level), 32'd5);
        tk(1'b1, 1'b0, 1'b1, 8'h88);
        chk("simul5.level", 32'(wr_level), 32'd5);
        for (int i = 0; i < 40 && wr_level != 0; i++) tk(1'b1, 1'b0, 1'b0, 8'h00);
        chk("drain.empty", 32'(wr_level), 32'd0);
        chk("drain.no_und_yet", 32'(underrun), 32'd0);
        tk(1'b1, 1'b0, 1'b0, 8'h00);
        chk("und.blank1", 32'(dataLCD), 32'(BLANK));
        tk(1'b1, 1'b0, 1'b0, 8'h00);
        chk("und.blank2", 32'(dataLCD), 32'(BLANK));
        chk("und.flag", 32'(underrun), 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("und.clr", 32'(underrun), 32'd0);

        // ---------------- px_cnt saturation and blanking ----------------
        for (int i = 0; i < 25; i++) tk(1'b1, 1'b0, 1'b0, 8'h00);
        chk("px.saturate", 32'(px_cnt), 32'(PPL - 1));
        tk(1'b0, 1'b0, 1'b0, 8'h00);
        chk("blank.data", 32'(dataLCD), 32'h0);
        chk("blank.px", 32'(px_cnt), 32'h0);

        // ---------------- Reset mid-frame ----------------
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        tk(1'b1, 1'b0, 1'b0, 8'h00);
        chk("mid.pre.data", 32'(dataLCD), 32'hC0);
        #3;
        rst    = 1'b0;
        V_SYNC = 1'b1;
        #1;
        chk("mid.async.data", 32'(dataLCD), 32'h0);
        chk("mid.async.level", 32'(wr_level), 32'h0);
        chk("mid.async.px", 32'(px_cnt), 32'h0);
        @(posedge sys_clk);
        #1;
        model_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) tk(1'b1, 1'b1, 1'b0, 8'h00);
        chk("mid.nofs.level", 32'(wr_level), 32'd1);
        chk("mid.nofs.data", 32'(dataLCD), 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tk(1'b1, 1'b0, 1'b0, 8'h00);
        chk("mid.after_fs.data", 32'(dataLCD), 32'h5A);

        // ---------------- Randomized run against the model ----------------
        do_reset();
        begin
            bit ck, h, v, vs;
            int vs_low;
            ck     = 1'b0;
            h      = 1'b0;
            v      = 1'b1;
            vs     = 1'b1;
            vs_low = 0;
            for (int i = 0; i < 1500; i++) begin
                ck = ~ck;
                if (ck) begin
                    if ($urandom_range(0, 7) == 0) h = ~h;
                    v = ($urandom_range(0, 15) != 0);
                end
                if (vs_low > 0) begin
                    vs_low--;
                    vs = (vs_low == 0);
                end else if ($urandom_range(0, 99) == 0) begin
                    vs_low = int'($urandom_range(1, 4));
                    vs     = 1'b0;
                end
                cyc(ck, h, v, vs, ($urandom_range(0, 99) < 55), 8'($urandom),
                    ($urandom_range(0, 39) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
